// File: rtl/misr_bist_ctrl.sv
// misr_bist_ctrl: scan-BIST sequencer that alternates shift windows with capture pulses,
// then unloads the MISR and compares the frozen signature against a golden value.
module misr_bist_ctrl #(
    parameter int               CHAIN_LEN  = 16,
    parameter int               PAT_CNT    = 64,
    parameter int               SIG_W      = 13,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [SIG_W-1:0]             sig_i,
    output logic                         test_se_o,
    output logic                         capture_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         pass_o,
    output logic [$clog2(PAT_CNT+1)-1:0] pat_idx_o
);
    localparam int PW = $clog2(PAT_CNT+1);
    localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CW-1:0] LAST_SHIFT = CW'(CHAIN_LEN-1);
    localparam logic [PW-1:0] LAST_PAT   = PW'(PAT_CNT-1);
    localparam logic [PW-1:0] MAX_PAT    = PW'(PAT_CNT);

    typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pat_q, pat_d;
    logic            pass_q, pass_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        pass_d  = pass_q;
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            pat_d   = '0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_i) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    pat_d   = '0;
                    pass_d  = 1'b0;
                end
                SHIFT, UNLOAD: begin
                    cnt_d   = (cnt_q == LAST_SHIFT) ? '0 : cnt_q + CW'(1);
                    state_d = (cnt_q != LAST_SHIFT) ? state_q
                            : (state_q == SHIFT)    ? CAPTURE : COMPARE;
                end
                CAPTURE: begin
                    pat_d   = (pat_q < MAX_PAT) ? pat_q + PW'(1) : pat_q;
                    state_d = (pat_q == LAST_PAT) ? UNLOAD : SHIFT;
                end
                COMPARE: begin
                    pass_d  = (sig_i == GOLDEN_SIG);
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            pass_q  <= pass_d;
        end
    end

    // Outputs decode straight from flops, so no input reaches them combinationally.
    assign test_se_o = (state_q == SHIFT) || (state_q == UNLOAD);
    assign capture_o = (state_q == CAPTURE);
    assign busy_o    = (state_q == SHIFT) || (state_q == CAPTURE) ||
                       (state_q == UNLOAD) || (state_q == COMPARE);
    assign done_o    = (state_q == DONE);
    assign pass_o    = pass_q;
    assign pat_idx_o = pat_q;
endmodule

// File: tb/tb_misr_bist_ctrl.sv
// tb_misr_bist_ctrl: directed checks of the BIST sequencer with a 4x2 and a 1x1 configuration.
module tb_misr_bist_ctrl;
    localparam logic [12:0] G1 = 13'h00A5;
    localparam logic [12:0] G2 = 13'h1ABC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0, abort1 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic [12:0] sig1 = G1, sig2 = G2;
    logic        se1, cap1, busy1, done1, pass1;
    logic        se2, cap2, busy2, done2, pass2;
    logic [1:0]  pat1;
    logic        pat2;
    int          n_checks = 0;
    int          n_errs = 0;

    always #5 clk = ~clk;

    misr_bist_ctrl #(.CHAIN_LEN(4), .PAT_CNT(2), .SIG_W(13), .GOLDEN_SIG(G1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1), .sig_i(sig1),
        .test_se_o(se1), .capture_o(cap1), .busy_o(busy1), .done_o(done1),
        .pass_o(pass1), .pat_idx_o(pat1)
    );

    misr_bist_ctrl #(.CHAIN_LEN(1), .PAT_CNT(1), .SIG_W(13), .GOLDEN_SIG(G2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .abort_i(abort2), .sig_i(sig2),
        .test_se_o(se2), .capture_o(cap2), .busy_o(busy2), .done_o(done2),
        .pass_o(pass2), .pat_idx_o(pat2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a run on the 4x2 instance and check every cycle 1..16 against the hand-derived timeline.
    task automatic run_basic(input logic exp_pass);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) tick();
            check($sformatf("se c%0d", c), 32'(se1), 32'((c >= 1 && c <= 4) || (c >= 6 && c <= 9) || (c >= 11 && c <= 14)));
            check($sformatf("cap c%0d", c), 32'(cap1), 32'(c == 5 || c == 10));
            check($sformatf("busy c%0d", c), 32'(busy1), 32'(c <= 15));
            check($sformatf("done c%0d", c), 32'(done1), 32'(c == 16));
            check($sformatf("pass c%0d", c), 32'(pass1), (c == 16) ? 32'(exp_pass) : 32'd0);
            check($sformatf("pat c%0d", c), 32'(pat1), (c <= 5) ? 32'd0 : (c <= 10) ? 32'd1 : 32'd2);
        end
    endtask

    initial begin
        tick();
        check("rst se", 32'(se1), 0);
        check("rst busy", 32'(busy1), 0);
        check("rst done", 32'(done1), 0);
        check("rst pass", 32'(pass1), 0);
        check("rst cap", 32'(cap1), 0);
        rst_n = 1'b1;
        tick();
        check("idle busy", 32'(busy1), 0);

        run_basic(1'b1);
        repeat (3) tick();
        check("hold done", 32'(done1), 1);
        check("hold pass", 32'(pass1), 1);
        check("hold pat", 32'(pat1), 2);

        sig1 = G1 ^ 13'h1;
        run_basic(1'b0);
        sig1 = G1;

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (6) tick();
        check("pre-abort se", 32'(se1), 1);
        check("pre-abort pat", 32'(pat1), 1);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("abort se", 32'(se1), 0);
        check("abort busy", 32'(busy1), 0);
        check("abort pat", 32'(pat1), 0);
        check("abort done", 32'(done1), 0);
        tick();
        check("abort stays idle", 32'(busy1), 0);
        run_basic(1'b1);

        start1 = 1'b1;
        tick();
        repeat (15) tick();
        check("relaunch done", 32'(done1), 1);
        check("relaunch pass", 32'(pass1), 1);
        tick();
        check("relaunch se", 32'(se1), 1);
        check("relaunch done clr", 32'(done1), 0);
        check("relaunch pass clr", 32'(pass1), 0);
        start1 = 1'b0;
        repeat (15) tick();
        check("relaunch2 done", 32'(done1), 1);

        start1 = 1'b1;
        abort1 = 1'b1;
        tick();
        start1 = 1'b0;
        abort1 = 1'b0;
        check("abort>start busy", 32'(busy1), 0);
        check("abort>start done", 32'(done1), 0);
        check("abort>start pass", 32'(pass1), 0);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (11) tick();
        check("unload se", 32'(se1), 1);
        check("unload pat", 32'(pat1), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async se", 32'(se1), 0);
        check("async busy", 32'(busy1), 0);
        check("async pat", 32'(pat1), 0);
        check("async pass", 32'(pass1), 0);
        tick();
        #2 rst_n = 1'b1;
        repeat (3) tick();
        check("post-rst busy", 32'(busy1), 0);
        check("post-rst se", 32'(se1), 0);

        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("e1 se c1", 32'(se2), 1);
        check("e1 cap c1", 32'(cap2), 0);
        tick();
        check("e1 se c2", 32'(se2), 0);
        check("e1 cap c2", 32'(cap2), 1);
        check("e1 pat c2", 32'(pat2), 0);
        tick();
        check("e1 se c3", 32'(se2), 1);
        check("e1 pat c3", 32'(pat2), 1);
        tick();
        check("e1 se c4", 32'(se2), 0);
        check("e1 busy c4", 32'(busy2), 1);
        check("e1 done c4", 32'(done2), 0);
        tick();
        check("e1 done c5", 32'(done2), 1);
        check("e1 pass c5", 32'(pass2), 1);
        check("e1 busy c5", 32'(busy2), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/misr_bist_ctrl.md
# misr_bist_ctrl

Scan-BIST sequencer that drives the shared `test_se` line of the multiply-block scan chains and their 13-bit MISR compactor. It alternates CHAIN_LEN-cycle shift windows with single-cycle functional capture pulses for PAT_CNT patterns, then runs a final unload shift. It then compares the frozen MISR signature against a golden value and reports pass or fail. It sits between the top-level test interface and the MISR/scan-chain datapath.

## Interface
- CHAIN_LEN, 16, scan chain length in shift cycles per pattern; must be ≥ 1.
- PAT_CNT, 64, number of patterns applied; must be ≥ 1.
- SIG_W, 13, MISR signature width.
- GOLDEN_SIG, 13'h0, expected final signature.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE or DONE; launches a run.
- abort  in  1  level; highest priority; returns to IDLE from any state.
- sig  in  SIG_W  MISR signature.
- test_se  out  1  scan enable to the chains and the MISR.
- capture  out  1  one-cycle functional capture strobe.
- busy  out  1  high in SHIFT, CAPTURE, UNLOAD and COMPARE.
- done  out  1  high while in DONE.
- pass  out  1  registered compare result; valid while done=1.
- pat_idx  out  clog2(PAT_CNT+1)  index of the pattern being shifted or captured.

## Operation
- States: IDLE, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
- Output decode, all from the state register (Moore):
  - test_se = SHIFT or UNLOAD.
  - capture = CAPTURE.
  - done = DONE.
- Reset values: state IDLE; shift_cnt 0; pat_idx 0; pass 0. Consequently test_se, capture, busy and done are all 0.
- IDLE/DONE with start=1 (and abort=0): go to SHIFT, clear shift_cnt, pat_idx and pass.
- DONE with start=0: hold. done, pass and pat_idx=PAT_CNT stay stable.
- SHIFT: increment shift_cnt each cycle. When shift_cnt=CHAIN_LEN-1, clear shift_cnt and go to CAPTURE.
- CAPTURE: lasts exactly one cycle.
  - If pat_idx=PAT_CNT-1: increment pat_idx and go to UNLOAD.
  - Otherwise: increment pat_idx and go to SHIFT.
- UNLOAD: CHAIN_LEN shift cycles, counted as in SHIFT, to flush the last response. Then go to COMPARE.
- COMPARE: one cycle with test_se=0, so the MISR holds its value. Register pass <= (sig == GOLDEN_SIG), then go to DONE.
- abort=1 in any state: next state is IDLE, counters cleared, pass <= 0. abort overrides a simultaneous start.
- Counters never wrap. shift_cnt is bounded to CHAIN_LEN-1; pat_idx saturates at PAT_CNT.
- Asynchronous reset mid-run forces the reset values immediately. No partial result is retained.

## Timing
- Let E0 be the rising edge that samples start=1 in IDLE.
- test_se is high for the CHAIN_LEN cycles following E0.
- Pattern k (0-based) occupies edges E(k·(CHAIN_LEN+1)) through E(k·(CHAIN_LEN+1)+CHAIN_LEN). The last of these edges is the CAPTURE cycle.
- UNLOAD begins at E(PAT_CNT·(CHAIN_LEN+1)).
- COMPARE begins at E(PAT_CNT·(CHAIN_LEN+1)+CHAIN_LEN).
- done rises one edge after COMPARE begins.
- Per run: test_se is high for exactly (PAT_CNT+1)·CHAIN_LEN cycles in total, and capture pulses exactly PAT_CNT times. Two capture pulses are never adjacent.
- No combinational path from start, abort or sig to any output.
- pass is updated only on the COMPARE→DONE edge, on abort, or on a new start.

## Test plan
- Basic run, CHAIN_LEN=4, PAT_CNT=2, sig forced to GOLDEN_SIG, start pulsed 1 cycle:
  - test_se high for cycles 1–4, 6–9 and 11–14.
  - capture high at cycles 5 and 10.
  - done=1 and pass=1 from cycle 16.
  - busy is low again from cycle 16.
- Same run with sig = GOLDEN_SIG^1 during COMPARE -> done=1, pass=0.
- Abort asserted during the second SHIFT window -> next cycle IDLE: test_se=0, busy=0, pat_idx=0. A subsequent start runs the full sequence again.
- Restart from DONE: start=1 while done=1 -> pass clears and SHIFT resumes the next cycle. Holding start high after DONE, with no abort, immediately relaunches each run.
- rst_n pulsed low mid-UNLOAD -> outputs go to their reset values asynchronously, with no clock edge required. The FSM stays in IDLE after release until start.
- Edge case CHAIN_LEN=1, PAT_CNT=1:
  - test_se high at cycles 1 and 3; capture at cycle 2.
  - COMPARE at cycle 4; done at cycle 5.
